// File: rtl/tse_reg_responder.sv
// Register-slave end of the TSE MAC control interface.
// Answers single-cycle rd/wr strobes, holds the MAC control registers and
// applies a fixed reg_busy hold-off after every accepted access.
module tse_reg_responder #(
   parameter int unsigned WAIT_CYCLES  = 2,
   parameter logic [31:0] REV_VALUE    = 32'h0000_0901,
   parameter logic [31:0] CMD_CFG_RST  = 32'h0000_0000,
   parameter logic [7:0]  ADDR_REV     = 8'h00,
   parameter logic [7:0]  ADDR_SCRATCH = 8'h01,
   parameter logic [7:0]  ADDR_CMD_CFG = 8'h02,
   parameter logic [7:0]  ADDR_MAC_LO  = 8'h03,
   parameter logic [7:0]  ADDR_MAC_HI  = 8'h04
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] reg_data_in,
   input  logic [7:0]  reg_addr,
   input  logic        reg_rd,
   input  logic        reg_wr,
   output logic [31:0] reg_data_out,
   output logic        reg_busy,
   output logic [47:0] mac_addr,
   output logic [31:0] cmd_config,
   output logic        cfg_update,
   output logic        mac_valid,
   output logic        proto_err
);

   localparam bit         HasWait = (WAIT_CYCLES != 0);
   localparam logic [3:0] CntLoad = HasWait ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;

   logic [31:0] rdata_q, rdata_d;
   logic [47:0] mac_q, mac_d;
   logic [31:0] cmd_q, cmd_d;
   logic [31:0] scratch_q, scratch_d;
   logic        upd_q, upd_d;
   logic        lo_seen_q, lo_seen_d;
   logic        hi_seen_q, hi_seen_d;
   logic        perr_q, perr_d;

   logic        any_strobe;
   logic        accept;
   logic        wr_acc;
   logic        rd_acc;
   logic [31:0] rd_mux;

   assign any_strobe = reg_rd | reg_wr;
   assign accept     = (state_q == StIdle) & any_strobe;
   assign wr_acc     = accept & reg_wr;
   // A simultaneous rd+wr keeps only the write.
   assign rd_acc     = accept & reg_rd & ~reg_wr;

   // FSM state and wait counter register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM next state: hold off for WAIT_CYCLES cycles after each accept
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (accept && HasWait) begin
               state_d = StBusy;
               cnt_d   = CntLoad;
            end
         end
         StBusy: begin
            if (cnt_q == 4'd0) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      reg_busy = (state_q == StBusy);
   end

   // Read data mux; exact 8-bit address compare, unmapped reads return 0
   always_comb begin
      rd_mux = 32'h0;
      if (reg_addr == ADDR_REV) begin
         rd_mux = REV_VALUE;
      end else if (reg_addr == ADDR_SCRATCH) begin
         rd_mux = scratch_q;
      end else if (reg_addr == ADDR_CMD_CFG) begin
         rd_mux = cmd_q;
      end else if (reg_addr == ADDR_MAC_LO) begin
         rd_mux = mac_q[31:0];
      end else if (reg_addr == ADDR_MAC_HI) begin
         rd_mux = {16'h0, mac_q[47:32]};
      end
   end

   // Register file next state: writes, read capture and sticky flags
   always_comb begin
      rdata_d   = rdata_q;
      mac_d     = mac_q;
      cmd_d     = cmd_q;
      scratch_d = scratch_q;
      upd_d     = 1'b0;
      lo_seen_d = lo_seen_q;
      hi_seen_d = hi_seen_q;
      perr_d    = perr_q;

      if (wr_acc) begin
         if (reg_addr == ADDR_SCRATCH) begin
            scratch_d = reg_data_in;
         end else if (reg_addr == ADDR_CMD_CFG) begin
            cmd_d = reg_data_in;
            upd_d = 1'b1;
         end else if (reg_addr == ADDR_MAC_LO) begin
            mac_d[31:0] = reg_data_in;
            lo_seen_d   = 1'b1;
         end else if (reg_addr == ADDR_MAC_HI) begin
            mac_d[47:32] = reg_data_in[15:0];
            hi_seen_d    = 1'b1;
         end
      end

      if (rd_acc) begin
         rdata_d = rd_mux;
      end

      // Strobes during hold-off, or rd+wr together, are handshake violations.
      if ((reg_busy && any_strobe) || (accept && reg_rd && reg_wr)) begin
         perr_d = 1'b1;
      end
   end

   // Register file state
   always_ff @(posedge clk) begin
      if (!rst) begin
         rdata_q   <= 32'h0;
         mac_q     <= 48'h0;
         cmd_q     <= CMD_CFG_RST;
         scratch_q <= 32'h0;
         upd_q     <= 1'b0;
         lo_seen_q <= 1'b0;
         hi_seen_q <= 1'b0;
         perr_q    <= 1'b0;
      end else begin
         rdata_q   <= rdata_d;
         mac_q     <= mac_d;
         cmd_q     <= cmd_d;
         scratch_q <= scratch_d;
         upd_q     <= upd_d;
         lo_seen_q <= lo_seen_d;
         hi_seen_q <= hi_seen_d;
         perr_q    <= perr_d;
      end
   end

   assign reg_data_out = rdata_q;
   assign mac_addr     = mac_q;
   assign cmd_config   = cmd_q;
   assign cfg_update   = upd_q;
   assign mac_valid    = lo_seen_q & hi_seen_q;
   assign proto_err    = perr_q;

endmodule

// File: doc/tse_reg_responder.md
Name: tse_reg_responder

Overview:
- Register-slave end of the TSE MAC control interface: it answers the single-cycle read/write strobes issued by the MAC configuration master and honours the `reg_busy` hold-off.
- Holds the MAC control registers the master programs: `command_config`, MAC address low/high, scratch and revision.
- Drives the programmed values to the datapath.
- Used as the control-register front end of our MAC model in the DE2 test environments, and as a bench responder for the config master.

Parameters:
- `WAIT_CYCLES`, 2: number of cycles `reg_busy` is held high after each accepted access (0..15; 0 means `reg_busy` never asserts).
- `REV_VALUE`, 32'h0000_0901: read-only value returned at `ADDR_REV`.
- `CMD_CFG_RST`, 32'h0000_0000: reset value of `command_config`.
- `ADDR_REV`, 8'h00: revision register address.
- `ADDR_SCRATCH`, 8'h01: scratch register address.
- `ADDR_CMD_CFG`, 8'h02: `command_config` address.
- `ADDR_MAC_LO`, 8'h03: MAC address bits [31:0].
- `ADDR_MAC_HI`, 8'h04: MAC address bits [47:32], held in register bits [15:0].

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-low reset.
- `reg_data_in`, in, 32: write data from the master.
- `reg_addr`, in, 8: register address from the master.
- `reg_rd`, in, 1: read strobe.
- `reg_wr`, in, 1: write strobe.
- `reg_data_out`, out, 32: read data to the master.
- `reg_busy`, out, 1: hold-off to the master.
- `mac_addr`, out, 48: programmed station MAC address.
- `cmd_config`, out, 32: programmed `command_config`.
- `cfg_update`, out, 1: one-cycle pulse after each `command_config` write.
- `mac_valid`, out, 1: both MAC halves written since reset.
- `proto_err`, out, 1: sticky flag for a handshake violation.

Behaviour:
- Reset (`rst`=0 at a rising edge) sets: `reg_busy`=0, `reg_data_out`=0, `mac_addr`=0, `cmd_config`=`CMD_CFG_RST`, scratch=0, `cfg_update`=0, `mac_valid`=0, `proto_err`=0, FSM=IDLE, wait counter=0.
- Reset mid-access aborts the access. `reg_busy` is 0 in the cycle after the reset edge and no register is updated.
- FSM states:
  - IDLE: `reg_busy`=0. An access is accepted on any edge where `reg_rd` or `reg_wr` is 1.
  - BUSY: `reg_busy`=1. The counter loads `WAIT_CYCLES`-1 on accept and decrements each cycle; the FSM returns to IDLE when the counter is 0.
  - Transition IDLE->BUSY on accept only if `WAIT_CYCLES`>0; otherwise the FSM stays in IDLE and back-to-back accesses are legal every cycle.
- Timing: for an access accepted at edge N, `reg_busy` is high for exactly `WAIT_CYCLES` cycles starting after edge N, and low again after edge N+`WAIT_CYCLES`.
- Write, accepted at edge N: the target register updates at edge N (visible in cycle N+1).
  - `ADDR_MAC_LO` writes `mac_addr[31:0]`.
  - `ADDR_MAC_HI` writes `mac_addr[47:32]` from `reg_data_in[15:0]`; bits [31:16] are discarded.
  - `ADDR_CMD_CFG` writes `cmd_config` and sets `cfg_update`=1 for cycle N+1 only.
  - `ADDR_SCRATCH` writes scratch.
  - Writes to `ADDR_REV` and to unmapped addresses are ignored.
- Read, accepted at edge N: `reg_data_out` is registered at edge N. It is valid from cycle N+1 and held until the next accepted read.
  - `ADDR_MAC_HI` reads {16'h0, `mac_addr[47:32]`}.
  - Unmapped addresses read 0.
  - Writes do not change `reg_data_out`.
- `mac_valid`: two internal sticky bits record that LO and HI have each been written. `mac_valid` is 1 from the cycle after the second of those writes, in either order. It clears only on reset.
- `rd` and `wr` both high at accept: the write is performed, the read is dropped (`reg_data_out` unchanged) and `proto_err` is set.
- `rd` or `wr` high while `reg_busy`=1: the strobe is dropped with no register or timing effect, and `proto_err` is set.
- `proto_err` is sticky until reset.
- No address decode on the upper bits beyond an exact 8-bit compare.

Test Plan:
- Reset, then `rd` `ADDR_REV` for one cycle at edge N: `reg_data_out`=32'h0000_0901 from N+1; `reg_busy` high cycles N+1..N+2 and low at N+3.
- Write 8'h03=32'h4433_2211, then after busy clears write 8'h04=32'hABCD_6655:
  - `mac_addr`=48'h6655_4433_2211;
  - `mac_valid` rises only after the second write;
  - reading 8'h04 returns 32'h0000_6655.
- Write 8'h02=32'h0000_0203: `cmd_config`=32'h0000_0203 and `cfg_update` is high for exactly one cycle (N+1). A second identical write pulses it again.
- `wr` to 8'h01 asserted while `reg_busy`=1: scratch unchanged and `proto_err`=1. After a reset, `rd`+`wr` together to 8'h01 with 32'hDEAD_BEEF: scratch=32'hDEAD_BEEF, `reg_data_out` unchanged, `proto_err`=1.
- Write 8'h7F=32'hFFFF_FFFF, then read 8'h7F: returns 0. Write 8'h00: revision still 32'h0000_0901.
- With `WAIT_CYCLES`=0: writes to 8'h03, 8'h04, 8'h02 on three consecutive cycles all take effect and `reg_busy` stays 0. With `WAIT_CYCLES`=2, reset asserted mid-busy: `reg_busy`=0 the next cycle, all registers at reset defaults, `mac_valid`=0.
